// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the two-requester APB arbiter
// Contents: FSM state encoding, requester count, one-hot grant constants.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam int NUM_REQ = 2;

  localparam logic [NUM_REQ-1:0] GNT_NONE = 2'b00;
  localparam logic [NUM_REQ-1:0] GNT_M0   = 2'b01;
  localparam logic [NUM_REQ-1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - combinational 2-way round-robin picker
// Ports:
//   req_i  : pending requests, bit0 = M0, bit1 = M1
//   last_i : requester granted most recently (0 = M0, 1 = M1)
//   gnt_o  : one-hot winner, 00 when nothing is pending
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    case (req_i)
      2'b01:   gnt_o = GNT_M0;
      2'b10:   gnt_o = GNT_M1;
      // Collision: the requester that did not win last time goes first.
      2'b11:   gnt_o = last_i ? GNT_M0 : GNT_M1;
      default: gnt_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/apb_two_master_arbiter.sv
// rtl/apb_two_master_arbiter.sv - shares one downstream APB3 port between two APB3 requesters
// Ports:
//   PCLK, PRESETN                     : clock, asynchronous active-low reset
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA_Mx : requester inputs (PENABLE_Mx is not used)
//   PRDATA/PREADY/PSLVERR_Mx          : registered response, PREADY_Mx is a one-cycle pulse
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA_D : downstream request
//   PRDATA/PREADY/PSLVERR_D           : downstream response
//   GNT                               : one-hot current owner
//   TO_PULSE                          : one-cycle pulse when the watchdog aborts a transfer
module apb_two_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          PCLK,
  input  logic          PRESETN,
  input  logic          PSEL_M0,
  input  logic          PENABLE_M0,
  input  logic [AW-1:0] PADDR_M0,
  input  logic          PWRITE_M0,
  input  logic [DW-1:0] PWDATA_M0,
  output logic [DW-1:0] PRDATA_M0,
  output logic          PREADY_M0,
  output logic          PSLVERR_M0,
  input  logic          PSEL_M1,
  input  logic          PENABLE_M1,
  input  logic [AW-1:0] PADDR_M1,
  input  logic          PWRITE_M1,
  input  logic [DW-1:0] PWDATA_M1,
  output logic [DW-1:0] PRDATA_M1,
  output logic          PREADY_M1,
  output logic          PSLVERR_M1,
  output logic          PSEL_D,
  output logic          PENABLE_D,
  output logic [AW-1:0] PADDR_D,
  output logic          PWRITE_D,
  output logic [DW-1:0] PWDATA_D,
  input  logic [DW-1:0] PRDATA_D,
  input  logic          PREADY_D,
  input  logic          PSLVERR_D,
  output logic [1:0]    GNT,
  output logic          TO_PULSE
);

  // Counter must hold 0..TIMEOUT; keep at least one bit when the watchdog is off.
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               to_q, to_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               timeout_hit;
  logic               unused_penable;

  // Requester enables carry no arbitration information.
  assign unused_penable = PENABLE_M0 ^ PENABLE_M1;

  apb_rr_pick u_pick (
    .req_i  ({PSEL_M1, PSEL_M0}),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_gnt != GNT_NONE) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt[1];
          addr_d  = pick_gnt[1] ? PADDR_M1  : PADDR_M0;
          wr_d    = pick_gnt[1] ? PWRITE_M1 : PWRITE_M0;
          wdata_d = pick_gnt[1] ? PWDATA_M1 : PWDATA_M0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // A slave completing on the last permitted cycle beats the watchdog.
        if (PREADY_D) begin
          rdata_d = wr_q ? '0 : PRDATA_D;
          err_d   = PSLVERR_D;
          to_d    = 1'b0;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
        if (PREADY_D || timeout_hit) begin
          addr_d  = '0;
          wr_d    = 1'b0;
          wdata_d = '0;
        end
      end

      ST_DONE: begin
        gnt_d   = GNT_NONE;
        rdata_d = '0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign PSEL_D     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE_D  = (state_q == ST_ACCESS);
  assign PADDR_D    = addr_q;
  assign PWRITE_D   = wr_q;
  assign PWDATA_D   = wdata_q;
  assign GNT        = gnt_q;
  assign TO_PULSE   = to_q;

  assign PREADY_M0  = (state_q == ST_DONE) && gnt_q[0];
  assign PREADY_M1  = (state_q == ST_DONE) && gnt_q[1];
  assign PRDATA_M0  = {DW{PREADY_M0}} & rdata_q;
  assign PRDATA_M1  = {DW{PREADY_M1}} & rdata_q;
  assign PSLVERR_M0 = PREADY_M0 && err_q;
  assign PSLVERR_M1 = PREADY_M1 && err_q;

endmodule
